// File: rtl/crypto_wallet_cpu_debug_pkg.sv
// Shared constants and types for the CPU JTAG debug slave (system-clock side).
package crypto_wallet_cpu_debug_pkg;

    localparam int unsigned SR_W_DEF       = 38;
    localparam int unsigned IR_W_DEF       = 2;
    localparam int unsigned ACTION_BIT_DEF = 34;

    localparam logic [IR_W_DEF-1:0] IR_OCIMEM    = 2'd0;
    localparam logic [IR_W_DEF-1:0] IR_TRACECTRL = 2'd1;
    localparam logic [IR_W_DEF-1:0] IR_BREAK     = 2'd2;
    localparam logic [IR_W_DEF-1:0] IR_TRACEMEM  = 2'd3;

    typedef struct packed {
        logic [IR_W_DEF-1:0] ir;
        logic [SR_W_DEF-1:0] sr;
    } cmd_entry_t;

endpackage

// File: rtl/crypto_wallet_cpu_debug_strobe_sync.sv
// Level synchroniser with registered rising-edge pulse; resets to all-ones so a
// strobe already high at reset release is not mistaken for a new event.
module crypto_wallet_cpu_debug_strobe_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic strobe_i,
    output logic pulse_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   pulse_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sync_q  <= '1;
            prev_q  <= 1'b1;
            pulse_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], strobe_i};
            prev_q  <= sync_q[SYNC_STAGES-1];
            pulse_q <= sync_q[SYNC_STAGES-1] & ~prev_q;
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/crypto_wallet_cpu_debug_cmd_sync.sv
// System-clock side of the CPU JTAG debug slave: synchronises update-DR/IR,
// buffers captured commands in a FWFT FIFO and decodes per-IR action strobes.
module crypto_wallet_cpu_debug_cmd_sync
    import crypto_wallet_cpu_debug_pkg::*;
#(
    parameter int unsigned SR_W        = SR_W_DEF,
    parameter int unsigned IR_W        = IR_W_DEF,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned ACTION_BIT  = ACTION_BIT_DEF,
    localparam int unsigned NUM_IR     = 2 ** IR_W,
    localparam int unsigned LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              vs_udr,
    input  logic              vs_uir,
    input  logic [IR_W-1:0]   ir_in,
    input  logic [SR_W-1:0]   sr,
    input  logic              cmd_ready,
    input  logic              ovf_clr,
    output logic              cmd_valid,
    output logic [IR_W-1:0]   cmd_ir,
    output logic [SR_W-1:0]   cmd_sr,
    output logic [SR_W-1:0]   jdo,
    output logic [NUM_IR-1:0] take_action,
    output logic [NUM_IR-1:0] take_no_action,
    output logic              ir_update,
    output logic [IR_W-1:0]   ir_latched,
    output logic              overflow,
    output logic [LVL_W-1:0]  fifo_level
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned ENT_W = IR_W + SR_W;
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

    logic udr_evt;
    logic uir_evt;

    crypto_wallet_cpu_debug_strobe_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_udr_sync (
        .clk_i   (clk),
        .reset_i (reset),
        .strobe_i(vs_udr),
        .pulse_o (udr_evt)
    );

    crypto_wallet_cpu_debug_strobe_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_uir_sync (
        .clk_i   (clk),
        .reset_i (reset),
        .strobe_i(vs_uir),
        .pulse_o (uir_evt)
    );

    logic [ENT_W-1:0]  mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic [ENT_W-1:0]  head;
    logic [IR_W-1:0]   head_ir;
    logic [SR_W-1:0]   head_sr;
    logic              fifo_empty;
    logic              fifo_full;
    logic              pop;
    logic              push;
    logic              drop;

    logic [SR_W-1:0]   jdo_q, jdo_d;
    logic [NUM_IR-1:0] take_action_q, take_action_d;
    logic [NUM_IR-1:0] take_no_action_q, take_no_action_d;
    logic              ir_update_q, ir_update_d;
    logic [IR_W-1:0]   ir_latched_q, ir_latched_d;
    logic              overflow_q, overflow_d;

    assign head    = mem_q[rd_ptr_q];
    assign head_ir = head[ENT_W-1:SR_W];
    assign head_sr = head[SR_W-1:0];

    // A push into a full FIFO only succeeds when the head leaves in the same cycle.
    always_comb begin
        fifo_empty = (level_q == '0);
        fifo_full  = (level_q == LVL_FULL);
        pop        = !fifo_empty && cmd_ready;
        push       = udr_evt && (!fifo_full || pop);
        drop       = udr_evt && fifo_full && !pop;

        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

        level_d = level_q;
        if (push && !pop) begin
            level_d = level_q + LVL_W'(1);
        end else if (pop && !push) begin
            level_d = level_q - LVL_W'(1);
        end
    end

    always_comb begin
        take_action_d    = '0;
        take_no_action_d = '0;
        jdo_d            = jdo_q;
        if (pop) begin
            jdo_d = head_sr;
            if (head_sr[ACTION_BIT]) begin
                take_action_d[head_ir] = 1'b1;
            end else begin
                take_no_action_d[head_ir] = 1'b1;
            end
        end
    end

    always_comb begin
        ir_update_d  = uir_evt;
        ir_latched_d = uir_evt ? ir_in : ir_latched_q;
        // A drop in the same cycle as a clear keeps the flag set.
        if (drop) begin
            overflow_d = 1'b1;
        end else if (ovf_clr) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
            level_q          <= '0;
            jdo_q            <= '0;
            take_action_q    <= '0;
            take_no_action_q <= '0;
            ir_update_q      <= 1'b0;
            ir_latched_q     <= '0;
            overflow_q       <= 1'b0;
        end else begin
            wr_ptr_q         <= wr_ptr_d;
            rd_ptr_q         <= rd_ptr_d;
            level_q          <= level_d;
            jdo_q            <= jdo_d;
            take_action_q    <= take_action_d;
            take_no_action_q <= take_no_action_d;
            ir_update_q      <= ir_update_d;
            ir_latched_q     <= ir_latched_d;
            overflow_q       <= overflow_d;
        end
    end

    // Storage needs no reset: reads are gated by the occupancy count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {ir_in, sr};
        end
    end

    assign cmd_valid      = !fifo_empty;
    assign cmd_ir         = fifo_empty ? '0 : head_ir;
    assign cmd_sr         = fifo_empty ? '0 : head_sr;
    assign fifo_level     = level_q;
    assign jdo            = jdo_q;
    assign take_action    = take_action_q;
    assign take_no_action = take_no_action_q;
    assign ir_update      = ir_update_q;
    assign ir_latched     = ir_latched_q;
    assign overflow       = overflow_q;

endmodule

// File: doc/crypto_wallet_cpu_debug_cmd_sync.md
Name: crypto_wallet_cpu_debug_cmd_sync

Overview:
Parametrised system-clock side of the CPU JTAG debug slave. It synchronises the virtual-JTAG update-DR and update-IR strobes into `clk`, and captures the shift register and IR at each update-DR. Captured commands are buffered in a small FIFO with a ready/valid handoff to the OCI/break/trace logic. For every IR code it decodes one-cycle take_action / take_no_action strobes, so back-to-back JTAG commands are no longer lost when the consumer is busy.

Parameters:
SR_W, 38, width of JTAG data shift register / jdo
IR_W, 2, virtual IR width; NUM_IR = 2**IR_W decoded channels
FIFO_DEPTH, 4, command buffer entries (power of 2, >=2)
SYNC_STAGES, 2, synchroniser flops per strobe (>=2)
ACTION_BIT, 34, sr bit selecting action vs no-action strobe

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
vs_udr  in  1  update-DR level from tck domain, asynchronous to clk
vs_uir  in  1  update-IR level from tck domain, asynchronous to clk
ir_in  in  IR_W  virtual IR, stable while vs_udr/vs_uir high
sr  in  SR_W  shift register, stable while vs_udr high
cmd_ready  in  1  consumer accepts head command
ovf_clr  in  1  clears sticky overflow
cmd_valid  out  1  FIFO non-empty
cmd_ir  out  IR_W  IR of head command
cmd_sr  out  SR_W  sr of head command
jdo  out  SR_W  sr of last accepted command (registered)
take_action  out  NUM_IR  one-hot pulse, accepted command with sr[ACTION_BIT]=1
take_no_action  out  NUM_IR  one-hot pulse, accepted command with sr[ACTION_BIT]=0
ir_update  out  1  one-cycle pulse per update-IR event
ir_latched  out  IR_W  IR captured at last update-IR
overflow  out  1  sticky: an update-DR was dropped
fifo_level  out  $clog2(FIFO_DEPTH)+1  occupancy

Behaviour:
- Reset values:
  - All outputs 0.
  - FIFO emptied; in-flight contents discarded on reset mid-operation.
  - Synchroniser chains and edge-detect flops reset to all-ones. A strobe held high across reset release therefore produces no event; one held low produces none either.
- Event detection:
  - Synchronised rising edge only; a high level lasting many cycles yields exactly one event.
  - Falling edges are ignored.
- udr event:
  - Push {ir_in, sr}, sampled on the edge-detect cycle.
  - Latency: an empty FIFO with vs_udr first sampled high at edge k gives cmd_valid=1 after edge k+SYNC_STAGES+1. This is SYNC_STAGES+2 cycles inclusive.
- uir event:
  - ir_latched <= ir_in; ir_update pulses for 1 cycle, same pipeline timing as push.
  - Does not touch the FIFO.
- Handshake:
  - Pop when cmd_valid && cmd_ready.
  - cmd_ir/cmd_sr are the head entry (FWFT), stable while cmd_valid && !cmd_ready.
- Strobes on pop:
  - The cycle after pop: jdo <= popped sr, and take_action[cmd_ir] or take_no_action[cmd_ir] is asserted for exactly 1 cycle.
  - All other strobe bits are 0. At most one bit across both vectors is set per cycle.
- Full:
  - A push while full and no pop in the same cycle drops the new command (the head is preserved) and sets overflow.
  - Push and pop in the same cycle while full: both succeed, level unchanged, no overflow.
- Empty:
  - Push and pop in the same cycle while empty is impossible (cmd_valid=0), so no bypass path exists.
- overflow clear:
  - Cleared by ovf_clr.
  - If ovf_clr coincides with a drop, overflow stays 1 (set wins).
- Pointers wrap modulo FIFO_DEPTH; fifo_level ranges 0..FIFO_DEPTH.
- Simultaneous udr and uir events are independent; both are processed in the same cycle.

Decomposition:
- Package crypto_wallet_cpu_debug_pkg:
  - SR_W/IR_W defaults.
  - IR code constants (IR_OCIMEM=0, IR_TRACECTRL=1, IR_BREAK=2, IR_TRACEMEM=3).
  - A typedef for the FIFO entry struct {ir, sr}.
- One sub-module, crypto_wallet_cpu_debug_strobe_sync: SYNC_STAGES synchroniser, all-ones reset, rising-edge pulse output. It is instantiated twice (udr, uir).
- FIFO and decode are inline.

Test Plan:
1. Latency: reset, then vs_udr high for 10 cycles with ir_in=2, sr=38'h04_0000_00AB. Expect cmd_valid exactly 4 cycles after first sample with cmd_ir=2; with cmd_ready=1, take_action[2] pulses once the following cycle and jdo=38'h04_0000_00AB. No second event.
2. No-action decode: ir_in=0, sr[34]=0, cmd_ready=1. Expect take_no_action=4'b0001 for 1 cycle, take_action=0.
3. Overflow: cmd_ready=0, 5 udr events with sr=1..5. Expect fifo_level=4 and overflow=1; then drain shows cmd_sr 1,2,3,4 in order and entry 5 is lost. Assert ovf_clr during a 6th drop; overflow must remain 1.
4. Full push/pop: FIFO full, cmd_ready=1 on the same cycle as a push edge. Expect level stays 4 and overflow stays 0.
5. Reset behaviour: vs_udr high during reset and held after release. Expect no cmd_valid. Then assert reset mid-queue with level=3 and expect level=0, cmd_valid=0 and all strobes 0 the next cycle.
6. Update-IR: vs_uir pulse with ir_in=3, concurrent with a udr event (ir_in=3). Expect ir_update for 1 cycle, ir_latched=3, and level incremented by 1.
